// File: rtl/gt_victim_cache.sv
`default_nettype none
// ============================================================================
// Module   : gt_victim_cache
// Purpose  : Fully associative victim cache beside the direct-mapped L1 array.
//            Captures lines evicted from that array and answers its miss
//            lookups. A hit returns the line and frees the entry, so the line
//            moves back into the direct-mapped array. Saturating hit and miss
//            counters feed performance reporting.
// Ports    : CLK, RST          - clock (rising edge), async active-high reset
//            lookup_valid/addr - miss lookup request (addr[31:5] = line tag)
//            evict_valid/tag/data - line displaced from the direct-map array
//            resp_valid/hit/data  - registered lookup response (data 0 on miss)
//            occupancy          - number of valid entries
//            hit_cnt, miss_cnt  - saturating 16-bit event counters
// Revision : 1.0 - initial release
// ============================================================================
module gt_victim_cache #(
    parameter int ENTRIES = 8,
    parameter int LINE_W  = 256,
    parameter int TAG_W   = 27
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         lookup_valid,
    input  logic [31:0]                  lookup_addr,
    input  logic                         evict_valid,
    input  logic [TAG_W-1:0]             evict_tag,
    input  logic [LINE_W-1:0]            evict_data,
    output logic                         resp_valid,
    output logic                         resp_hit,
    output logic [LINE_W-1:0]            resp_data,
    output logic [$clog2(ENTRIES):0]     occupancy,
    output logic [15:0]                  hit_cnt,
    output logic [15:0]                  miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [ENTRIES];
    logic [LINE_W-1:0]  r_data [ENTRIES];
    logic [IDX_W-1:0]   r_rrPtr;

    logic               r_respValid;
    logic               r_respHit;
    logic [LINE_W-1:0]  r_respData;
    logic [OCC_W-1:0]   r_occupancy;
    logic [15:0]        r_hitCnt;
    logic [15:0]        r_missCnt;

    // ------------------------------------------------------------------
    // Tag compare against pre-edge contents
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]   w_lookupTag;
    logic               w_unusedAddrBits;
    logic [ENTRIES-1:0] w_lookupMatch;

    assign w_lookupTag      = lookup_addr[31:32-TAG_W];
    // Byte offset within the line plays no part in the lookup.
    assign w_unusedAddrBits = ^lookup_addr[31-TAG_W:0];

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_lookupCmp
            assign w_lookupMatch[g] = r_valid[g] && (r_tag[g] == w_lookupTag);
        end
    endgenerate

    logic             w_hitAny;
    logic [IDX_W-1:0] w_hitIdx;

    always_comb begin
        w_hitAny = 1'b0;
        w_hitIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_lookupMatch[i]) begin
                w_hitAny = 1'b1;
                w_hitIdx = IDX_W'(i);
            end
        end
        w_hitAny = w_hitAny && lookup_valid;
    end

    // Valid bits after the lookup frees its entry; the insert is evaluated
    // against this view so a hit slot can be reused in the same cycle.
    logic [ENTRIES-1:0] w_validAfterLookup;

    always_comb begin
        w_validAfterLookup = r_valid;
        if (w_hitAny) begin
            w_validAfterLookup[w_hitIdx] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Insert slot selection
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] w_evictMatch;

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_evictCmp
            assign w_evictMatch[g] = w_validAfterLookup[g] && (r_tag[g] == evict_tag);
        end
    endgenerate

    logic             w_evMatchAny;
    logic [IDX_W-1:0] w_evMatchIdx;
    logic             w_freeAny;
    logic [IDX_W-1:0] w_freeIdx;

    always_comb begin
        w_evMatchAny = 1'b0;
        w_evMatchIdx = '0;
        w_freeAny    = 1'b0;
        w_freeIdx    = '0;
        // Descending scan leaves the lowest index as the winner.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_evictMatch[i]) begin
                w_evMatchAny = 1'b1;
                w_evMatchIdx = IDX_W'(i);
            end
            if (!w_validAfterLookup[i]) begin
                w_freeAny = 1'b1;
                w_freeIdx = IDX_W'(i);
            end
        end
    end

    logic [IDX_W-1:0]   w_wrIdx;
    logic               w_rrAdvance;
    logic [ENTRIES-1:0] w_validNext;
    logic [OCC_W-1:0]   w_occNext;

    always_comb begin
        w_rrAdvance = 1'b0;
        if (w_evMatchAny) begin
            w_wrIdx = w_evMatchIdx;
        end else if (w_freeAny) begin
            w_wrIdx = w_freeIdx;
        end else begin
            w_wrIdx     = r_rrPtr;
            w_rrAdvance = evict_valid;
        end

        w_validNext = w_validAfterLookup;
        if (evict_valid) begin
            w_validNext[w_wrIdx] = 1'b1;
        end

        w_occNext = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_occNext = w_occNext + OCC_W'(w_validNext[i]);
        end
    end

    // ------------------------------------------------------------------
    // Control state (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid     <= '0;
            r_rrPtr     <= '0;
            r_respValid <= 1'b0;
            r_respHit   <= 1'b0;
            r_respData  <= '0;
            r_occupancy <= '0;
            r_hitCnt    <= '0;
            r_missCnt   <= '0;
        end else begin
            r_valid     <= w_validNext;
            r_occupancy <= w_occNext;
            // Power-of-two depth: natural wrap gives the modulo.
            if (w_rrAdvance) begin
                r_rrPtr <= r_rrPtr + 1'b1;
            end

            r_respValid <= lookup_valid;
            r_respHit   <= w_hitAny;
            r_respData  <= w_hitAny ? r_data[w_hitIdx] : '0;

            if (lookup_valid) begin
                if (w_hitAny) begin
                    if (r_hitCnt != C_CNT_MAX) begin
                        r_hitCnt <= r_hitCnt + 16'd1;
                    end
                end else if (r_missCnt != C_CNT_MAX) begin
                    r_missCnt <= r_missCnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag/data arrays: qualified by r_valid, so no reset is needed
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (evict_valid) begin
            r_tag[w_wrIdx]  <= evict_tag;
            r_data[w_wrIdx] <= evict_data;
        end
    end

    assign resp_valid = r_respValid;
    assign resp_hit   = r_respHit;
    assign resp_data  = r_respData;
    assign occupancy  = r_occupancy;
    assign hit_cnt    = r_hitCnt;
    assign miss_cnt   = r_missCnt;

endmodule
`default_nettype wire

// File: tb/tb_gt_victim_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_gt_victim_cache
// Purpose  : Directed self-checking bench for gt_victim_cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gt_victim_cache;

    localparam int ENTRIES = 8;
    localparam int LINE_W  = 256;
    localparam int TAG_W   = 27;

    logic              CLK;
    logic              RST;
    logic              lookup_valid;
    logic [31:0]       lookup_addr;
    logic              evict_valid;
    logic [TAG_W-1:0]  evict_tag;
    logic [LINE_W-1:0] evict_data;
    logic              resp_valid;
    logic              resp_hit;
    logic [LINE_W-1:0] resp_data;
    logic [3:0]        occupancy;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    int checks = 0;
    int errors = 0;
    int expHits = 0;
    int expMiss = 0;

    gt_victim_cache #(
        .ENTRIES(ENTRIES),
        .LINE_W (LINE_W),
        .TAG_W  (TAG_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .lookup_valid(lookup_valid),
        .lookup_addr (lookup_addr),
        .evict_valid (evict_valid),
        .evict_tag   (evict_tag),
        .evict_data  (evict_data),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_data   (resp_data),
        .occupancy   (occupancy),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [LINE_W-1:0] lineOf(input logic [TAG_W-1:0] t);
        logic [31:0] w;
        w = {5'b0, t} ^ 32'hC0DE_0000;
        return {8{w}};
    endfunction

    function automatic logic [31:0] addrOf(input logic [TAG_W-1:0] t);
        return {t, 5'b0};
    endfunction

    // One clock: inputs already driven; sample #1 after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        lookup_valid = 1'b0;
        lookup_addr  = '0;
        evict_valid  = 1'b0;
        evict_tag    = '0;
        evict_data   = '0;
    endtask

    task automatic doInsert(input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d);
        evict_valid = 1'b1;
        evict_tag   = t;
        evict_data  = d;
        cyc();
        idleInputs();
    endtask

    task automatic doLookup(input logic [31:0] a);
        lookup_valid = 1'b1;
        lookup_addr  = a;
        cyc();
        idleInputs();
    endtask

    task automatic pulseReset();
        #2 RST = 1'b1;
        #1 RST = 1'b0;
        expHits = 0;
        expMiss = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        RST = 1'b0;
        #2 RST = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_data !== '0 ||
            occupancy !== 4'd0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b h=%b d!=0:%b occ=%0d hc=%0d mc=%0d, want all 0",
                     resp_valid, resp_hit, (resp_data != '0), occupancy, hit_cnt, miss_cnt);
        end
        #1 RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (resp_valid !== 1'b0 || occupancy !== 4'd0) begin
                errors++;
                $display("FAIL idle_%0d: got v=%b occ=%0d, want v=0 occ=0", i, resp_valid, occupancy);
            end
        end
    endtask

    task automatic test_insert_hit();
        doInsert(27'h0000123, {32{8'hA5}});
        checks++;
        if (occupancy !== 4'd1) begin
            errors++;
            $display("FAIL ins_occ: got %0d want 1", occupancy);
        end
        doLookup(32'h0000_2460);
        expHits++;
        checks++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_data !== {32{8'hA5}} ||
            occupancy !== 4'd0 || hit_cnt !== 16'(expHits)) begin
            errors++;
            $display("FAIL first_hit: got v=%b h=%b d=%h occ=%0d hc=%0d, want 1 1 A5.. 0 %0d",
                     resp_valid, resp_hit, resp_data, occupancy, hit_cnt, expHits);
        end
        doLookup(32'h0000_2460);
        expMiss++;
        checks++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_data !== '0 ||
            miss_cnt !== 16'(expMiss)) begin
            errors++;
            $display("FAIL second_miss: got v=%b h=%b d=%h mc=%0d, want 1 0 0 %0d",
                     resp_valid, resp_hit, resp_data, miss_cnt, expMiss);
        end
        cyc();
        checks++;
        if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_data !== '0) begin
            errors++;
            $display("FAIL pulse_end: got v=%b h=%b, want 0 0", resp_valid, resp_hit);
        end
    endtask

    task automatic test_fill_rr();
        for (int t = 1; t <= 8; t++) begin
            doInsert(TAG_W'(t), lineOf(TAG_W'(t)));
        end
        checks++;
        if (occupancy !== 4'd8) begin
            errors++;
            $display("FAIL fill_occ: got %0d want 8", occupancy);
        end
        // Full: tag 9 replaces entry 0 (tag 1), pointer moves to 1.
        doInsert(27'd9, lineOf(27'd9));
        doLookup(addrOf(27'd1));
        expMiss++;
        checks++;
        if (resp_hit !== 1'b0 || occupancy !== 4'd8) begin
            errors++;
            $display("FAIL rr_tag1_gone: got h=%b occ=%0d, want 0 8", resp_hit, occupancy);
        end
        // Tag 10 replaces entry 1 (tag 2), pointer moves to 2.
        doInsert(27'd10, lineOf(27'd10));
        doLookup(addrOf(27'd9));
        expHits++;
        checks++;
        if (resp_hit !== 1'b1 || resp_data !== lineOf(27'd9) || occupancy !== 4'd7) begin
            errors++;
            $display("FAIL rr_tag9_hit: got h=%b d=%h occ=%0d, want 1 %h 7",
                     resp_hit, resp_data, occupancy, lineOf(27'd9));
        end
        doLookup(addrOf(27'd2));
        expMiss++;
        checks++;
        if (resp_hit !== 1'b0 || resp_data !== '0) begin
            errors++;
            $display("FAIL rr_tag2_gone: got h=%b d=%h, want 0 0", resp_hit, resp_data);
        end
        // Refill freed entry 0; array is full again with rr pointer at 2.
        doInsert(27'd11, lineOf(27'd11));
    endtask

    task automatic test_swap();
        lookup_valid = 1'b1;
        lookup_addr  = addrOf(27'd5);
        evict_valid  = 1'b1;
        evict_tag    = 27'h40;
        evict_data   = lineOf(27'h40);
        cyc();
        idleInputs();
        expHits++;
        checks++;
        if (resp_hit !== 1'b1 || resp_data !== lineOf(27'd5) || occupancy !== 4'd8) begin
            errors++;
            $display("FAIL swap_resp: got h=%b d=%h occ=%0d, want 1 %h 8",
                     resp_hit, resp_data, occupancy, lineOf(27'd5));
        end
        doLookup(addrOf(27'h40));
        expHits++;
        checks++;
        if (resp_hit !== 1'b1 || resp_data !== lineOf(27'h40)) begin
            errors++;
            $display("FAIL swap_new_tag: got h=%b d=%h, want 1 %h", resp_hit, resp_data, lineOf(27'h40));
        end
        // Entry 4 free again; 0x41 fills it, 0x42 must replace entry 2 (tag 3).
        doInsert(27'h41, lineOf(27'h41));
        doInsert(27'h42, lineOf(27'h42));
        doLookup(addrOf(27'd3));
        expMiss++;
        checks++;
        if (resp_hit !== 1'b0) begin
            errors++;
            $display("FAIL swap_rr_victim: got h=%b want 0 (tag 3 evicted)", resp_hit);
        end
        doLookup(addrOf(27'd4));
        expHits++;
        checks++;
        if (resp_hit !== 1'b1 || resp_data !== lineOf(27'd4) ||
            hit_cnt !== 16'(expHits) || miss_cnt !== 16'(expMiss)) begin
            errors++;
            $display("FAIL swap_rr_keep: got h=%b hc=%0d mc=%0d, want 1 %0d %0d",
                     resp_hit, hit_cnt, miss_cnt, expHits, expMiss);
        end
    endtask

    task automatic test_same_tag_lookup_insert();
        lookup_valid = 1'b1;
        lookup_addr  = addrOf(27'h50) | 32'h1F;
        evict_valid  = 1'b1;
        evict_tag    = 27'h50;
        evict_data   = lineOf(27'h50);
        cyc();
        idleInputs();
        expMiss++;
        checks++;
        if (resp_hit !== 1'b0 || occupancy !== 4'd8 || miss_cnt !== 16'(expMiss)) begin
            errors++;
            $display("FAIL same_tag_miss: got h=%b occ=%0d mc=%0d, want 0 8 %0d",
                     resp_hit, occupancy, miss_cnt, expMiss);
        end
        doLookup(addrOf(27'h50));
        expHits++;
        checks++;
        if (resp_hit !== 1'b1 || resp_data !== lineOf(27'h50) || occupancy !== 4'd7) begin
            errors++;
            $display("FAIL same_tag_after: got h=%b occ=%0d, want 1 7", resp_hit, occupancy);
        end
    endtask

    task automatic test_reset_mid();
        doInsert(27'h77, lineOf(27'h77));
        doInsert(27'h78, lineOf(27'h78));
        lookup_valid = 1'b1;
        lookup_addr  = addrOf(27'h77);
        @(posedge CLK);
        idleInputs();
        #2 RST = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || occupancy !== 4'd0 ||
            hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b h=%b occ=%0d hc=%0d mc=%0d, want all 0",
                     resp_valid, resp_hit, occupancy, hit_cnt, miss_cnt);
        end
        #1 RST = 1'b0;
        expHits = 0;
        expMiss = 0;
        cyc();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_resp: got v=%b want 0", resp_valid);
        end
        doLookup(addrOf(27'h78));
        expMiss++;
        checks++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || miss_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_reset_cleared: got v=%b h=%b mc=%0d, want 1 0 1",
                     resp_valid, resp_hit, miss_cnt);
        end
    endtask

    task automatic test_duplicate();
        pulseReset();
        doInsert(27'd7, {8{32'h1111_1111}});
        doInsert(27'd7, {8{32'h2222_2222}});
        checks++;
        if (occupancy !== 4'd1) begin
            errors++;
            $display("FAIL dup_occ: got %0d want 1", occupancy);
        end
        doLookup(addrOf(27'd7));
        expHits++;
        checks++;
        if (resp_hit !== 1'b1 || resp_data !== {8{32'h2222_2222}}) begin
            errors++;
            $display("FAIL dup_data: got h=%b d=%h, want 1 2222..", resp_hit, resp_data);
        end
        doInsert(27'h99, '0);
        doLookup(addrOf(27'h99));
        expHits++;
        checks++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_data !== '0 || hit_cnt !== 16'(expHits)) begin
            errors++;
            $display("FAIL zero_line: got v=%b h=%b hc=%0d, want 1 1 %0d", resp_valid, resp_hit, hit_cnt, expHits);
        end
    endtask

    task automatic test_saturation();
        int n;
        doInsert(27'h5A, lineOf(27'h5A));
        // Lookup and re-insert the same tag each cycle: one hit per cycle.
        lookup_valid = 1'b1;
        lookup_addr  = addrOf(27'h5A);
        evict_valid  = 1'b1;
        evict_tag    = 27'h5A;
        evict_data   = lineOf(27'h5A);
        n = 32'hFFFE - expHits;
        for (int i = 0; i < n; i++) begin
            cyc();
        end
        checks++;
        if (hit_cnt !== 16'hFFFE || occupancy !== 4'd1) begin
            errors++;
            $display("FAIL sat_pre: got hc=%h occ=%0d, want FFFE 1", hit_cnt, occupancy);
        end
        cyc();
        checks++;
        if (hit_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %h want FFFF", hit_cnt);
        end
        cyc();
        idleInputs();
        checks++;
        if (hit_cnt !== 16'hFFFF || resp_hit !== 1'b1 || miss_cnt !== 16'(expMiss)) begin
            errors++;
            $display("FAIL sat_hold: got hc=%h h=%b mc=%0d, want FFFF 1 %0d", hit_cnt, resp_hit, miss_cnt, expMiss);
        end
    endtask

    initial begin
        test_reset();
        test_insert_hit();
        test_fill_rr();
        test_swap();
        test_same_tag_lookup_insert();
        test_reset_mid();
        test_duplicate();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
